// File: rtl/bfu_pipe.sv
// Radix-2 DIT butterfly, 4-stage valid/ready pipeline, sticky overflow.
// Define BFU_SAT_EN to clamp out-of-range results instead of wrapping.
module bfu_pipe #(
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int TFRAC = TW - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_r,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_r,
  input  logic [DW-1:0] b_i,
  input  logic [TW-1:0] w_r,
  input  logic [TW-1:0] w_i,
  input  logic          inverse,
  input  logic          scale,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] ao_r,
  output logic [DW-1:0] ao_i,
  output logic [DW-1:0] bo_r,
  output logic [DW-1:0] bo_i,
  output logic          ovf,
  input  logic          ovf_clr
);
  localparam int PW = DW + TW + 2;
  localparam int XW = DW + 2;
  localparam logic signed [PW-1:0] RND =
    PW'(1) << (TFRAC - 1);

  logic adv;
  logic v1_q, v2_q, v3_q, v4_q;

  assign adv       = !v4_q || out_ready;
  assign in_ready  = adv && !rst;
  assign out_valid = v4_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
    end
  end

  // S1: operands; conj(W) negates w_i one bit wider so -min is exact
  logic signed [DW-1:0] a1r_q, a1i_q, b1r_q, b1i_q;
  logic signed [TW-1:0] w1r_q;
  logic signed [TW:0]   wi_x, w1i_d, w1i_q;
  logic                 sc1_q;

  assign wi_x  = {w_i[TW-1], w_i};
  assign w1i_d = inverse ? -wi_x : wi_x;

  always_ff @(posedge clk) begin
    if (adv) begin
      a1r_q <= a_r;
      a1i_q <= a_i;
      b1r_q <= b_r;
      b1i_q <= b_i;
      w1r_q <= w_r;
      w1i_q <= w1i_d;
      sc1_q <= scale;
    end
  end

  // S2: full-precision complex product
  logic signed [PW-1:0] pr_d, pi_d, pr_q, pi_q;
  logic signed [DW-1:0] a2r_q, a2i_q;
  logic                 sc2_q;

  assign pr_d = PW'(b1r_q) * PW'(w1r_q)
              - PW'(b1i_q) * PW'(w1i_q);
  assign pi_d = PW'(b1r_q) * PW'(w1i_q)
              + PW'(b1i_q) * PW'(w1r_q);

  always_ff @(posedge clk) begin
    if (adv) begin
      pr_q  <= pr_d;
      pi_q  <= pi_d;
      a2r_q <= a1r_q;
      a2i_q <= a1i_q;
      sc2_q <= sc1_q;
    end
  end

  // S3: round-half-up and drop fraction bits
  logic signed [XW-1:0] t3r_d, t3i_d, t3r_q, t3i_q;
  logic signed [DW-1:0] a3r_q, a3i_q;
  logic                 sc3_q;

  assign t3r_d = XW'((pr_q + RND) >>> TFRAC);
  assign t3i_d = XW'((pi_q + RND) >>> TFRAC);

  always_ff @(posedge clk) begin
    if (adv) begin
      t3r_q <= t3r_d;
      t3i_q <= t3i_d;
      a3r_q <= a2r_q;
      a3i_q <= a2i_q;
      sc3_q <= sc2_q;
    end
  end

  // S4: add/sub, optional halving, range reduction
  function automatic logic signed [XW-1:0] scl(
    input logic signed [XW-1:0] x,
    input logic                 s
  );
    return s ? (x + XW'(1)) >>> 1 : x;
  endfunction

  function automatic logic fits(
    input logic signed [XW-1:0] x
  );
    return (&x[XW-1:DW-1]) || !(|x[XW-1:DW-1]);
  endfunction

  function automatic logic [DW-1:0] red(
    input logic signed [XW-1:0] x
  );
`ifdef BFU_SAT_EN
    if (fits(x)) return x[DW-1:0];
    else if (x[XW-1]) return {1'b1, {(DW-1){1'b0}}};
    else return {1'b0, {(DW-1){1'b1}}};
`else
    return x[DW-1:0];
`endif
  endfunction

  logic signed [XW-1:0] sr, si, dr, di;
  logic                 ovf4;

  assign sr = scl(XW'(a3r_q) + t3r_q, sc3_q);
  assign si = scl(XW'(a3i_q) + t3i_q, sc3_q);
  assign dr = scl(XW'(a3r_q) - t3r_q, sc3_q);
  assign di = scl(XW'(a3i_q) - t3i_q, sc3_q);
  assign ovf4 = !(fits(sr) && fits(si)
               && fits(dr) && fits(di));

  logic [DW-1:0] aor_q, aoi_q, bor_q, boi_q;
  logic          ovf_d, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      aor_q <= '0;
      aoi_q <= '0;
      bor_q <= '0;
      boi_q <= '0;
    end else if (adv && v3_q) begin
      aor_q <= red(sr);
      aoi_q <= red(si);
      bor_q <= red(dr);
      boi_q <= red(di);
    end
  end

  // a fresh overflow outranks a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (adv && v3_q && ovf4) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ao_r = aor_q;
  assign ao_i = aoi_q;
  assign bo_r = bor_q;
  assign bo_i = boi_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_bfu_pipe.sv
// Directed-vector bench for bfu_pipe with an in-order result scoreboard.
// Expected overflow result follows BFU_SAT_EN.
module tb_bfu_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, inverse, scale;
  logic out_valid, out_ready, ovf, ovf_clr;
  logic signed [15:0] a_r, a_i, b_r, b_i, w_r, w_i;
  logic signed [15:0] ao_r, ao_i, bo_r, bo_i;

  bfu_pipe #(.DW(16), .TW(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
    .w_r(w_r), .w_i(w_i),
    .inverse(inverse), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .ao_r(ao_r), .ao_i(ao_i), .bo_r(bo_r), .bo_i(bo_i),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

`ifdef BFU_SAT_EN
  localparam int OVF_AO = 32767;
`else
  localparam int OVF_AO = -5537;
`endif

  typedef struct {int ar; int ai; int br; int bi;} res_t;
  res_t q[$];
  res_t cur;
  int checks = 0;
  int errors = 0;
  int emit_cnt = 0;
  int acc_cnt = 0;

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic vec(input int ar, ai, br, bi, wr, wi,
                     input logic inv, sc,
                     input int ear, eai, ebr, ebi);
    a_r = 16'(ar); a_i = 16'(ai);
    b_r = 16'(br); b_i = 16'(bi);
    w_r = 16'(wr); w_i = 16'(wi);
    inverse = inv; scale = sc; in_valid = 1'b1;
    cur = '{ear, eai, ebr, ebi};
  endtask

  task automatic tick();
    res_t e;
    #1;
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        emit_cnt++;
        if (q.size() == 0) chk("spurious", q.size(), 1);
        else begin
          e = q.pop_front();
          chk("ao_r", int'(ao_r), e.ar);
          chk("ao_i", int'(ao_i), e.ai);
          chk("bo_r", int'(bo_r), e.br);
          chk("bo_i", int'(bo_i), e.bi);
        end
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        q.push_back(cur);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lat_chk(input string tag);
    int n;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      tick();
      n++;
    end
    chk(tag, n, 4);
  endtask

  task automatic drain();
    for (int g = 0; g < 20 && q.size() > 0; g++) tick();
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int sent, e0, n;
    rst = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
    in_valid = 1'b0;
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ao_r", int'(ao_r), 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    vec(1000, 0, 2000, 0, 32767, 0, 0, 0, 3000, 0, -1000, 0);
    lat_chk("lat_basic");
    drain();
    chk("basic_ovf", ovf, 0);

    vec(0, 0, 0, 1000, 0, -32767, 0, 0, 1000, 0, -1000, 0);
    tick();
    vec(0, 0, 0, 1000, 0, -32767, 1, 0, -1000, 0, 1000, 0);
    tick();
    in_valid = 1'b0;
    drain();

    vec(30000, 0, 30000, 0, 32767, 0, 0, 0, OVF_AO, 0, 1, 0);
    tick();
    in_valid = 1'b0;
    drain();
    chk("ovf_set", ovf, 1);
    tick(); tick(); tick();
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    vec(30000, 0, 30000, 0, 32767, 0, 0, 1, 30000, 0, 1, 0);
    tick();
    in_valid = 1'b0;
    drain();
    chk("scale_ovf", ovf, 0);

    out_ready = 1'b0;
    sent = 0;
    e0 = emit_cnt;
    for (int g = 0; g < 40 && sent < 6; g++) begin
      if (g == 8) begin
        chk("bp_accepts", sent, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_hold_ao_r", int'(ao_r), 100);
        chk("bp_hold_bo_i", int'(bo_i), 0);
        out_ready = 1'b1;
      end
      vec(100 * (sent + 1), sent, 0, 0, 0, 0, 0, 0,
          100 * (sent + 1), sent, 100 * (sent + 1), sent);
      n = acc_cnt;
      tick();
      if (acc_cnt > n) sent++;
    end
    in_valid = 1'b0;
    drain();
    chk("bp_emits", emit_cnt - e0, 6);

    vec(30000, 0, 30000, 0, 32767, 0, 0, 0, OVF_AO, 0, 1, 0);
    tick();
    in_valid = 1'b0;
    drain();
    chk("pre_rst_ovf", ovf, 1);
    for (int k = 0; k < 3; k++) begin
      vec(5 + k, 0, 0, 0, 0, 0, 0, 0, 5 + k, 0, 5 + k, 0);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_ao_r", int'(ao_r), 0);
    chk("mid_rst_bo_r", int'(bo_r), 0);
    chk("mid_rst_ovf", ovf, 0);
    vec(1000, 0, 2000, 0, 32767, 0, 0, 0, 3000, 0, -1000, 0);
    lat_chk("lat_post_rst");
    drain();

    ovf_clr = 1'b1;
    vec(30000, 0, 30000, 0, 32767, 0, 0, 0, OVF_AO, 0, 1, 0);
    tick();
    in_valid = 1'b0;
    for (int g = 0; g < 10 && !out_valid; g++) tick();
    chk("coll_ovf", ovf, 1);
    tick();
    chk("coll_then_clr", ovf, 0);
    ovf_clr = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
